// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode, funct and control encodings for the multicycle controller
package mc_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        RTYPE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
    } statetype_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: combinational aluop/funct -> alucontrol decoder
//   i_aluop      ADD, SUB or decode from funct
//   i_funct      instr[5:0]
//   o_alucontrol 4-bit ALU operation; unknown funct falls back to ADD
module mc_aludec
    import mc_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [5:0] i_funct,
    output logic [3:0] o_alucontrol
);
    logic [3:0] w_fdec;

    always_comb begin
        w_fdec = i_funct == F_SUB ? ALU_SUB :
                 i_funct == F_AND ? ALU_AND :
                 i_funct == F_OR  ? ALU_OR  :
                 i_funct == F_SLT ? ALU_SLT : ALU_ADD;
        o_alucontrol = i_aluop == ALUOP_SUB   ? ALU_SUB :
                       i_aluop == ALUOP_FUNCT ? w_fdec  : ALU_ADD;
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a shared-memory multicycle MIPS datapath
//   inputs : clk, reset (sync, active-high), op, funct, zero, mem_ready
//   outputs: iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb,
//            pcsrc, pcen, alucontrol, done (pulse in last cycle of each instruction)
//   HAS_MEM_READY=0 ignores mem_ready (always ready)
//   MC_BNE_EN defined: bne (op 000101) branches when zero=0; undefined: bne is a nop
module multicycle_controller
    import mc_pkg::*;
#(
    parameter bit HAS_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [3:0] alucontrol,
    output logic       done
);
    statetype_t r_state, w_next;
    logic       w_rdy, w_is_br, w_take;
    logic       w_memwrite, w_irwrite, w_regwrite, w_pcen, w_done;
    logic [1:0] w_aluop;

    assign w_rdy = HAS_MEM_READY ? mem_ready : 1'b1;

`ifdef MC_BNE_EN
    logic r_bne;
    always_ff @(posedge clk)
        if (reset) r_bne <= 1'b0;
        else if (r_state == DECODE) r_bne <= op == OP_BNE;
    assign w_is_br = op == OP_BEQ || op == OP_BNE;
    assign w_take  = r_bne ? ~zero : zero;
`else
    assign w_is_br = op == OP_BEQ;
    assign w_take  = zero;
`endif

    always_ff @(posedge clk)
        if (reset) r_state <= FETCH;
        else r_state <= w_next;

    always_comb begin
        w_next     = FETCH;
        iord       = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        w_regwrite = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_B;
        pcsrc      = PC_ALU;
        w_pcen     = 1'b0;
        w_aluop    = ALUOP_ADD;
        w_done     = 1'b0;
        case (r_state)
            FETCH: begin
                alusrcb   = SRCB_FOUR;
                w_irwrite = w_rdy;
                w_pcen    = w_rdy;
                w_next    = w_rdy ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb = SRCB_IMMSH;
                w_next  = (op == OP_LW || op == OP_SW) ? MEMADR :
                          op == OP_RTYPE ? RTYPE  :
                          w_is_br        ? BRANCH :
                          op == OP_ADDI  ? ADDIEX :
                          op == OP_J     ? JUMP   : FETCH;
                // unknown opcodes retire here as a nop
                w_done  = w_next == FETCH;
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                w_next  = op == OP_LW ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord   = 1'b1;
                w_next = w_rdy ? MEMWB : MEMRD;
            end
            MEMWB: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
                w_done     = w_rdy;
                w_next     = w_rdy ? FETCH : MEMWR;
            end
            RTYPE: begin
                alusrca = 1'b1;
                w_aluop = ALUOP_FUNCT;
                w_next  = ALUWB;
            end
            ALUWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                w_aluop = ALUOP_SUB;
                pcsrc   = PC_ALUOUT;
                w_pcen  = w_take;
                w_done  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                w_next  = ADDIWB;
            end
            ADDIWB: begin
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            JUMP: begin
                pcsrc  = PC_JUMP;
                w_pcen = 1'b1;
                w_done = 1'b1;
            end
            default: w_next = FETCH;
        endcase
    end

    // reset suppresses every write strobe so no partial access completes
    assign memwrite = w_memwrite & ~reset;
    assign irwrite  = w_irwrite  & ~reset;
    assign regwrite = w_regwrite & ~reset;
    assign pcen     = w_pcen     & ~reset;
    assign done     = w_done     & ~reset;

    mc_aludec u_aludec (
        .i_aluop      (w_aluop),
        .i_funct      (funct),
        .o_alucontrol (alucontrol)
    );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed self-checking bench for multicycle_controller
module tb_multicycle_controller;
    logic       clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b1;
    logic [5:0] op = 6'b0, funct = 6'b0;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, done;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] alucontrol;
    logic [16:0] outs;
    int n_cmp = 0, n_err = 0;

    // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,pcen,alucontrol,done}
    localparam logic [16:0] V_F    = 17'b0_0_1_0_0_0_0_01_00_1_0010_0;
    localparam logic [16:0] V_FS   = 17'b0_0_0_0_0_0_0_01_00_0_0010_0;
    localparam logic [16:0] V_D    = 17'b0_0_0_0_0_0_0_11_00_0_0010_0;
    localparam logic [16:0] V_DN   = 17'b0_0_0_0_0_0_0_11_00_0_0010_1;
    localparam logic [16:0] V_MA   = 17'b0_0_0_0_0_0_1_10_00_0_0010_0;
    localparam logic [16:0] V_MR   = 17'b1_0_0_0_0_0_0_00_00_0_0010_0;
    localparam logic [16:0] V_MWB  = 17'b0_0_0_0_1_1_0_00_00_0_0010_1;
    localparam logic [16:0] V_MWS  = 17'b1_1_0_0_0_0_0_00_00_0_0010_0;
    localparam logic [16:0] V_MWD  = 17'b1_1_0_0_0_0_0_00_00_0_0010_1;
    localparam logic [16:0] V_RSLT = 17'b0_0_0_0_0_0_1_00_00_0_0111_0;
    localparam logic [16:0] V_ROR  = 17'b0_0_0_0_0_0_1_00_00_0_0001_0;
    localparam logic [16:0] V_AWB  = 17'b0_0_0_1_0_1_0_00_00_0_0010_1;
    localparam logic [16:0] V_BT   = 17'b0_0_0_0_0_0_1_00_01_1_0110_1;
    localparam logic [16:0] V_BN   = 17'b0_0_0_0_0_0_1_00_01_0_0110_1;
    localparam logic [16:0] V_IWB  = 17'b0_0_0_0_0_1_0_00_00_0_0010_1;
    localparam logic [16:0] V_J    = 17'b0_0_0_0_0_0_0_00_10_1_0010_1;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen),
        .alucontrol(alucontrol), .done(done)
    );

    assign outs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                   alusrcb, pcsrc, pcen, alucontrol, done};

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (outs !== V_FS) begin n_err++; $display("FAIL reset outs=%b exp=%b", outs, V_FS); end
        reset = 1'b0;
    endtask

    task automatic test_lw();
        logic [16:0] e[5];
        int dn = 0;
        e = '{V_F, V_D, V_MA, V_MR, V_MWB};
        op = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b1;
            #1;
            n_cmp++;
            if (outs !== e[i]) begin n_err++; $display("FAIL lw[%0d] outs=%b exp=%b", i, outs, e[i]); end
            dn += int'(done);
            @(posedge clk); #1;
        end
        n_cmp++;
        if (dn != 1) begin n_err++; $display("FAIL lw_done_count got=%0d exp=1", dn); end
    endtask

    task automatic test_sw_wait();
        logic [16:0] e[7];
        logic        r[7];
        int dn = 0;
        e = '{V_F, V_D, V_MA, V_MWS, V_MWS, V_MWS, V_MWD};
        r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        op = 6'b101011;
        for (int i = 0; i < 7; i++) begin
            mem_ready = r[i];
            #1;
            n_cmp++;
            if (outs !== e[i]) begin n_err++; $display("FAIL sw[%0d] outs=%b exp=%b", i, outs, e[i]); end
            dn += int'(done);
            @(posedge clk); #1;
        end
        n_cmp++;
        if (dn != 1) begin n_err++; $display("FAIL sw_done_count got=%0d exp=1", dn); end
    endtask

    task automatic test_beq();
        logic [16:0] e[6];
        logic        z[6];
        e = '{V_F, V_D, V_BT, V_F, V_D, V_BN};
        z = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        op = 6'b000100;
        for (int i = 0; i < 6; i++) begin
            mem_ready = 1'b1;
            zero = z[i];
            #1;
            n_cmp++;
            if (outs !== e[i]) begin n_err++; $display("FAIL beq[%0d] outs=%b exp=%b", i, outs, e[i]); end
            @(posedge clk); #1;
        end
        zero = 1'b0;
    endtask

    task automatic test_rtype();
        logic [16:0] e[8];
        logic [5:0]  f[8];
        e = '{V_F, V_D, V_RSLT, V_AWB, V_F, V_D, V_ROR, V_AWB};
        f = '{6'b101010, 6'b101010, 6'b101010, 6'b101010,
              6'b100101, 6'b100101, 6'b100101, 6'b100101};
        op = 6'b000000;
        for (int i = 0; i < 8; i++) begin
            mem_ready = 1'b1;
            funct = f[i];
            #1;
            n_cmp++;
            if (outs !== e[i]) begin n_err++; $display("FAIL rtype[%0d] outs=%b exp=%b", i, outs, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addi_jump_stall();
        logic [16:0] e[9];
        logic        r[9];
        logic [5:0]  o[9];
        e = '{V_F, V_D, V_MA, V_IWB, V_FS, V_F, V_D, V_J, V_F};
        r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        o = '{6'b001000, 6'b001000, 6'b001000, 6'b001000,
              6'b000010, 6'b000010, 6'b000010, 6'b000010, 6'b111111};
        for (int i = 0; i < 9; i++) begin
            mem_ready = r[i];
            op = o[i];
            #1;
            n_cmp++;
            if (outs !== e[i]) begin n_err++; $display("FAIL addi_j[%0d] outs=%b exp=%b", i, outs, e[i]); end
            @(posedge clk); #1;
        end
        // op 111111 is unknown: retires from DECODE as a nop
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (outs !== V_DN) begin n_err++; $display("FAIL nop_decode outs=%b exp=%b", outs, V_DN); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [16:0] e[3];
        e = '{V_F, V_D, V_MA};
        op = 6'b101011;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            #1;
            n_cmp++;
            if (outs !== e[i]) begin n_err++; $display("FAIL rmid[%0d] outs=%b exp=%b", i, outs, e[i]); end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (outs !== V_MR) begin n_err++; $display("FAIL rmid_memwr outs=%b exp=%b", outs, V_MR); end
        @(posedge clk); #1;
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (outs !== V_FS) begin n_err++; $display("FAIL rmid_fetch outs=%b exp=%b", outs, V_FS); end
        @(posedge clk); #1;
    endtask

    task automatic test_bne();
`ifdef MC_BNE_EN
        logic [16:0] e[3];
        e = '{V_F, V_D, V_BT};
`else
        logic [16:0] e[3];
        e = '{V_F, V_DN, V_F};
`endif
        op = 6'b000101;
        zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            #1;
            n_cmp++;
            if (outs !== e[i]) begin n_err++; $display("FAIL bne[%0d] outs=%b exp=%b", i, outs, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq();
        test_rtype();
        test_addi_jump_stall();
        test_reset_mid();
        test_bne();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style FSM that sequences a shared-memory, multicycle MIPS datapath: one ALU and one unified instruction/data memory, reused across cycles.
- Decodes op/funct and drives per-cycle datapath enables and muxes, plus the 4-bit alucontrol.
- Stalls on a memory-ready handshake.
- Sits beside the datapath in the multicycle processor top, replacing the single-cycle combinational controller.

Parameters:
- HAS_MEM_READY, 1: when 0, mem_ready is ignored and treated as constantly 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- op  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag, current cycle
- mem_ready  in  1  memory has completed the access presented this cycle
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  load instruction register
- regdst  out  1  register write address: 0 = rt, 1 = rd
- memtoreg  out  1  register write data: 0 = ALUOut, 1 = data register
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A input: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- pcsrc  out  2  next-PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- pcen  out  1  PC register enable
- alucontrol  out  4  ALU operation
- done  out  1  one-cycle pulse in the final cycle of each instruction

Behaviour:
- Clock and reset: single clock clk. Synchronous, active-high reset. reset=1 at a posedge forces state FETCH.
- While reset is high, every write enable (memwrite, irwrite, regwrite, pcen, done) is forced to 0 combinationally.
- This holds for reset mid-instruction: no partial write completes.
- Outputs are decoded from state only, except:
  - pcen in BRANCH (depends on zero);
  - gating of the memory states by mem_ready.
- States and transitions:
  - FETCH: iord=0, alusrca=0, alusrcb=01, alucontrol=ADD, pcsrc=00. irwrite and pcen assert only when mem_ready=1. Go to DECODE if ready, else stay.
  - DECODE: alusrca=0, alusrcb=11, ADD (precomputes the branch target). Next state by op:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 -> RTYPE
    - 000100 -> BRANCH
    - 001000 -> ADDIEX
    - 000010 -> JUMP
    - any other op -> FETCH with done=1 (treated as nop)
  - MEMADR: alusrca=1, alusrcb=10, ADD. Next is MEMRD for lw, MEMWR for sw.
  - MEMRD: iord=1. Stay until mem_ready, then go to MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1, done=1. Next FETCH.
  - MEMWR: iord=1, memwrite=1 held continuously until mem_ready. done=1 in the ready cycle. Next FETCH.
  - RTYPE: alusrca=1, alusrcb=00, alucontrol from funct (see below). Next ALUWB.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1, done=1. Next FETCH.
  - BRANCH: alusrca=1, alusrcb=00, SUB, pcsrc=01, pcen=zero, done=1. Next FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, ADD. Next ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1, done=1. Next FETCH.
  - JUMP: pcsrc=10, pcen=1, done=1. Next FETCH.
- Don't-care outputs are driven to 0; alucontrol defaults to ADD.
- alucontrol encoding:
  - AND = 0000, OR = 0001, ADD = 0010, SUB = 0110, SLT = 0111.
  - funct mapping: 100000 -> ADD, 100010 -> SUB, 100100 -> AND, 100101 -> OR, 101010 -> SLT.
  - Unknown funct -> ADD, with the write still performed.
- Cycle counts with zero wait states:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown op 2.
  - Each mem_ready=0 cycle adds one cycle.
- Simultaneous reset and mem_ready: reset wins, and no irwrite or memwrite occurs.

Optional Feature:
- Macro MC_BNE_EN.
- Defined:
  - op 000101 (bne) goes from DECODE to BRANCH.
  - A registered flag, captured in DECODE, selects pcen = ~zero in BRANCH.
  - beq is unchanged.
- Undefined: op 000101 is an unknown op (nop, 2 cycles).

Decomposition:
- Package mc_pkg holds:
  - state enum statetype_t;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J;
  - funct constants;
  - ALU_* 4-bit codes;
  - alusrcb and pcsrc encodings.
- One natural sub-module: mc_aludec, a combinational funct/aluop -> alucontrol decoder.
- FSM and output decode stay in multicycle_controller.

Test Plan:
- Reset then lw (op=100011), mem_ready always 1:
  - states FETCH, DECODE, MEMADR, MEMRD, MEMWB;
  - regwrite=1 and memtoreg=1 only in cycle 5;
  - done pulses once.
- sw with mem_ready low 3 cycles in MEMWR: memwrite held for 4 cycles, done in the 4th, then FETCH.
- beq with zero=1, then with zero=0: pcen=1 in BRANCH with pcsrc=01 for zero=1; pcen=0 for zero=0; 3 cycles each.
- R-type funct 101010 then 100101: alucontrol 0111 in RTYPE, then 0001 on the next instruction; regdst=1 in ALUWB.
- reset asserted during MEMWR with mem_ready=1 in the same cycle: memwrite=0, next state FETCH, no done pulse.
- op=000101: 2-cycle nop without MC_BNE_EN; with MC_BNE_EN and zero=0, pcen=1 in BRANCH.
